// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data_mem control/data lines.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_op;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_ack, m1_rdata,
    output mem_addr, mem_wdata, mem_op, mem_wr,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_ack, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_ack, m1_rdata,
    input  mem_addr, mem_wdata, mem_op, mem_wr,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter sharing the single-port data_mem:
// grant in IDLE, one ACCESS cycle, then a registered ack/rdata.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state, state_nxt;
  logic              prio;
  logic              any_req;
  logic              win;
  logic              gnt0, gnt1;
  logic              lat_we;
  logic              lat_port;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              mem_op_c, mem_wr_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  assign any_req = bus.m0_req | bus.m1_req;
  // A lone requester always wins; prio only breaks a tie.
  assign win = (bus.m0_req & bus.m1_req) ? prio : bus.m1_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    mem_op_c    = 1'b0;
    mem_wr_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    case (state)
      IDLE: begin
        if (any_req && rst_n) begin
          state_nxt = ACCESS;
          gnt0      = ~win;
          gnt1      = win;
        end
      end
      ACCESS: begin
        state_nxt   = IDLE;
        mem_op_c    = 1'b1;
        mem_wr_c    = lat_we;
        mem_addr_c  = lat_addr;
        mem_wdata_c = lat_wdata;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the winner on grant; retire the access into ack/rdata at the end of ACCESS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio      <= 1'b0;
      lat_we    <= 1'b0;
      lat_port  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (state == IDLE && any_req) begin
        lat_port  <= win;
        lat_we    <= win ? bus.m1_we    : bus.m0_we;
        lat_addr  <= win ? bus.m1_addr  : bus.m0_addr;
        lat_wdata <= win ? bus.m1_wdata : bus.m0_wdata;
        prio      <= ~win;
      end
      if (state == ACCESS) begin
        if (lat_port) ack1 <= 1'b1;
        else          ack0 <= 1'b1;
        if (!lat_we) begin
          if (lat_port) rdata1 <= bus.mem_rdata;
          else          rdata0 <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_ack    = ack0;
  assign bus.m1_ack    = ack1;
  assign bus.m0_rdata  = rdata0;
  assign bus.m1_rdata  = rdata1;
  assign bus.mem_op    = mem_op_c;
  assign bus.mem_wr    = mem_wr_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;

endmodule
